reg_bank_write_demux: RTL and testbench
=======================================

// Module: reg_bank_write_demux
// PURPOSE
//  Write side of the 16x16-bit register bank. Accepts one write per cycle
//    (valid/ready), stages it one cycle, then commits it into one of 16 registers.
//  Outputs o1..o16 drive the bank read multiplexer inputs i1..i16 directly.
//  Exposes the staged write (pend_*) so the datapath can forward it before it commits.
// PARAMETERS
//  DATA_W    16  register width
//  NREG      16  number of registers; fixed to 2**SEL_W
//  SEL_W     4   destination select width
//  ZERO_REG  1   1: register 0 (o1) is hard-wired to 0 and writes to it are dropped
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  wr_valid   in   1       write request valid
//  wr_ready   out  1       block can accept the request this cycle
//  wr_sel     in   SEL_W   destination register; 0 selects o1, 15 selects o16
//  wr_data    in   DATA_W  data to write
//  hold       in   1       freeze commit; pending write is retained
//  o1..o16    out  DATA_W  register contents; o(k+1) holds register k
//  pend_valid out  1       a staged write is waiting to commit
//  pend_sel   out  SEL_W   destination of the staged write
//  pend_data  out  DATA_W  data of the staged write
//  wr_ack     out  1       one-cycle pulse in the cycle after a commit edge
// BEHAVIOUR
//  Reset: o1..o16 = 0, pend_valid = 0, pend_sel = 0, pend_data = 0, wr_ack = 0.
//    Takes effect immediately and asynchronously.
//  Accept: on an edge where wr_valid && wr_ready, pend_* <= {1, wr_sel, wr_data}.
//  Commit: on an edge where pend_valid && !hold:
//    - o[pend_sel] <= pend_data (dropped if ZERO_REG && pend_sel == 0);
//    - wr_ack <= 1; otherwise wr_ack <= 0.
//  wr_ready = !pend_valid || !hold. This is combinational, and wr_ready does not depend on wr_valid.
//  Pipeline:
//    - Accept and commit happen on the same edge: the old entry commits and the new entry loads.
//    - Throughput is 1 write/cycle while hold = 0.
//  If pend_valid commits and nothing is accepted on that edge, pend_valid <= 0.
//  Latency: request accepted at edge N -> o updated at edge N+1 (hold = 0) -> wr_ack high in cycle N+1..N+2.
//  Hold:
//    - With pend_valid = 1, hold = 1 keeps pend_* and all o unchanged and drives wr_ready = 0.
//    - With pend_valid = 0, hold = 1 still accepts one write into pend.
//  Dropped writes to reg 0 still pulse wr_ack; o1 stays 0 for all time when ZERO_REG = 1.
//  wr_data/wr_sel are ignored when wr_valid = 0 or wr_ready = 0. Only one register changes per edge.
//  Reset mid-operation: the pending write is discarded, no wr_ack is issued, and all registers clear.
//  Two consecutive writes to the same register: the second overwrites on the following edge (last write wins).
//  No state machine beyond pend_valid (EMPTY/FULL). wr_sel is used at full width; there is no out-of-range case.
// STRUCTURE
//  Shared package reg_bank_pkg: DATA_W, SEL_W, NREG, REG_ZERO_IDX constant.
//    The read multiplexer uses the same package.
//  Sub-module reg_word: DATA_W register with enable and async active-high reset.
//    Instantiated NREG times.
//    Enable is a one-hot decode of pend_sel gated by pend_valid && !hold.
//  Staging register and ack flop are in the top level.
// TESTING
//  1. Reset release, then wr_sel = 3, wr_data = 16'hBEEF, valid for 1 cycle:
//     pend_valid = 1 for 1 cycle, then o4 = BEEF, wr_ack pulses once, and all other outputs stay 0.
//  2. Back-to-back writes (sel 1 = 0001, 2 = 0002, ... 15 = 000F), valid every cycle, hold = 0:
//     wr_ready stays 1 and o2..o16 = 1..F, with 15 ack pulses on consecutive cycles.
//  3. Write sel 0 = FFFF with ZERO_REG = 1: o1 stays 0000 and wr_ack still pulses.
//     With ZERO_REG = 0, o1 = FFFF.
//  4. Write sel 5 = 1234, hold = 1 for 3 cycles:
//     - wr_ready = 0 and pend_data = 1234 throughout, with no ack;
//     - a second request is stalled;
//     - after hold drops, o6 = 1234 and the second write commits on the following edge.
//  5. Write sel 7 = AAAA then sel 7 = 5555 on consecutive cycles: o8 = AAAA for 1 cycle, then 5555.
//  6. Assert rst while pend holds sel 9 = C0DE:
//     - pend_valid -> 0 immediately and o10 remains 0;
//     - no wr_ack, and a write after release proceeds normally.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 16x16-bit register bank.
// The read multiplexer imports the same package, so widths stay consistent.
package reg_bank_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;
  localparam int NREG   = 2 ** SEL_W;

  localparam logic [SEL_W-1:0] REG_ZERO_IDX = '0;

  typedef enum logic {
    PEND_EMPTY,
    PEND_FULL
  } pend_state_t;

endpackage

// File: rtl/reg_bank_write_demux_if.sv
// Write request bus into the register bank: valid/ready handshake plus destination and data.
interface reg_bank_write_demux_if;
  import reg_bank_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);

endinterface

// File: rtl/reg_word.sv
// One register of the bank: loads d when en is high, clears asynchronously on rst.
module reg_word
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_write_demux.sv
// Write side of the register bank: stages one write for a cycle, then commits it into
// one of NREG registers through a one-hot enable decode.
module reg_bank_write_demux
  import reg_bank_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
)
(
  input  logic                   clk,
  input  logic                   rst,
  reg_bank_write_demux_if.slave  wr,
  input  logic                   hold,
  output logic [DATA_W-1:0]      o1,
  output logic [DATA_W-1:0]      o2,
  output logic [DATA_W-1:0]      o3,
  output logic [DATA_W-1:0]      o4,
  output logic [DATA_W-1:0]      o5,
  output logic [DATA_W-1:0]      o6,
  output logic [DATA_W-1:0]      o7,
  output logic [DATA_W-1:0]      o8,
  output logic [DATA_W-1:0]      o9,
  output logic [DATA_W-1:0]      o10,
  output logic [DATA_W-1:0]      o11,
  output logic [DATA_W-1:0]      o12,
  output logic [DATA_W-1:0]      o13,
  output logic [DATA_W-1:0]      o14,
  output logic [DATA_W-1:0]      o15,
  output logic [DATA_W-1:0]      o16,
  output logic                   pend_valid,
  output logic [SEL_W-1:0]       pend_sel,
  output logic [DATA_W-1:0]      pend_data,
  output logic                   wr_ack
);

  pend_state_t       state;
  pend_state_t       state_next;
  logic              accept;
  logic              commit;
  logic [NREG-1:0]   en;
  logic [DATA_W-1:0] q [NREG];

  assign accept = wr.wr_valid && wr.wr_ready;
  assign commit = pend_valid && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PEND_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A new accept always refills the slot, even on the edge where the old entry commits.
  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = PEND_FULL;
    end else if (commit) begin
      state_next = PEND_EMPTY;
    end
  end

  always_comb begin
    pend_valid  = (state == PEND_FULL);
    wr.wr_ready = (state == PEND_EMPTY) || !hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_sel  <= '0;
      pend_data <= '0;
      wr_ack    <= 1'b0;
    end else begin
      if (accept) begin
        pend_sel  <= wr.wr_sel;
        pend_data <= wr.wr_data;
      end
      wr_ack <= commit;
    end
  end

  // Writes to the hard-wired zero register still ack but never enable its flop.
  always_comb begin
    en = '0;
    if (commit) begin
      en[pend_sel] = 1'b1;
    end
    if (ZERO_REG) begin
      en[REG_ZERO_IDX] = 1'b0;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    reg_word u_word (
      .clk (clk),
      .rst (rst),
      .en  (en[k]),
      .d   (pend_data),
      .q   (q[k])
    );
  end

  assign o1  = q[0];
  assign o2  = q[1];
  assign o3  = q[2];
  assign o4  = q[3];
  assign o5  = q[4];
  assign o6  = q[5];
  assign o7  = q[6];
  assign o8  = q[7];
  assign o9  = q[8];
  assign o10 = q[9];
  assign o11 = q[10];
  assign o12 = q[11];
  assign o13 = q[12];
  assign o14 = q[13];
  assign o15 = q[14];
  assign o16 = q[15];

endmodule

// File: tb/tb_reg_bank_write_demux.sv
// Scoreboard bench for reg_bank_write_demux: expected commits are queued at issue time
// and checked by a monitor whenever wr_ack pulses.
module tb_reg_bank_write_demux;
  import reg_bank_pkg::*;

  typedef struct packed {
    logic [SEL_W-1:0]  idx;
    logic [DATA_W-1:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;

  logic [DATA_W-1:0] obs  [NREG];
  logic [DATA_W-1:0] obs0 [NREG];
  logic              pend_valid, pend_valid0;
  logic [SEL_W-1:0]  pend_sel, pend_sel0;
  logic [DATA_W-1:0] pend_data, pend_data0;
  logic              wr_ack, wr_ack0;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   ack_count = 0;
  exp_t expq [$];

  reg_bank_write_demux_if bus ();
  reg_bank_write_demux_if bus0 ();

  assign bus0.wr_valid = bus.wr_valid;
  assign bus0.wr_sel   = bus.wr_sel;
  assign bus0.wr_data  = bus.wr_data;

  always #5 clk = ~clk;

  reg_bank_write_demux #(.ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .wr(bus.slave), .hold(hold),
    .o1(obs[0]), .o2(obs[1]), .o3(obs[2]), .o4(obs[3]),
    .o5(obs[4]), .o6(obs[5]), .o7(obs[6]), .o8(obs[7]),
    .o9(obs[8]), .o10(obs[9]), .o11(obs[10]), .o12(obs[11]),
    .o13(obs[12]), .o14(obs[13]), .o15(obs[14]), .o16(obs[15]),
    .pend_valid(pend_valid), .pend_sel(pend_sel), .pend_data(pend_data), .wr_ack(wr_ack)
  );

  reg_bank_write_demux #(.ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr(bus0.slave), .hold(hold),
    .o1(obs0[0]), .o2(obs0[1]), .o3(obs0[2]), .o4(obs0[3]),
    .o5(obs0[4]), .o6(obs0[5]), .o7(obs0[6]), .o8(obs0[7]),
    .o9(obs0[8]), .o10(obs0[9]), .o11(obs0[10]), .o12(obs0[11]),
    .o13(obs0[12]), .o14(obs0[13]), .o15(obs0[14]), .o16(obs0[15]),
    .pend_valid(pend_valid0), .pend_sel(pend_sel0), .pend_data(pend_data0), .wr_ack(wr_ack0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] orAll(input int skip);
    logic [DATA_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i != skip) acc = acc | obs[i];
    end
    return acc;
  endfunction

  // Presents one request until accepted; returns one ns after the accepting edge.
  task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data,
                               input bit track, output int waited);
    exp_t e;
    bus.wr_valid = 1'b1;
    bus.wr_sel   = sel;
    bus.wr_data  = data;
    if (track) begin
      e.idx   = sel;
      e.value = (sel == 4'd0) ? 16'h0000 : data;
      expq.push_back(e);
    end
    waited = 0;
    @(negedge clk);
    while (!bus.wr_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.wr_ready) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL accept timeout: got wr_ready 0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle();
    bus.wr_valid = 1'b0;
    bus.wr_sel   = 4'hA;
    bus.wr_data  = 16'hDEAD;
  endtask

  // Monitor: every ack must match the oldest outstanding write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_ack) begin
        ack_count++;
        if (expq.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected ack: got wr_ack 1 expected 0 (no write outstanding)");
        end else begin
          e = expq.pop_front();
          checkOutput($sformatf("commit o%0d", e.idx + 1), 32'(obs[e.idx]), 32'(e.value));
          checkOutput("o1 hard zero", 32'(obs[0]), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   w;
    int   saved_acks;
    exp_t e;

    bus.wr_valid = 1'b0;
    bus.wr_sel   = '0;
    bus.wr_data  = '0;

    #2;
    checkOutput("reset o all", 32'(orAll(-1)), 32'h0);
    checkOutput("reset pend_valid", 32'(pend_valid), 32'h0);
    checkOutput("reset pend_sel", 32'(pend_sel), 32'h0);
    checkOutput("reset pend_data", 32'(pend_data), 32'h0);
    checkOutput("reset wr_ack", 32'(wr_ack), 32'h0);
    checkOutput("reset wr_ready", 32'(bus.wr_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single write to o4");
    applyStimulus(4'd3, 16'hBEEF, 1'b1, w);
    applyIdle();
    checkOutput("t1 pend_valid", 32'(pend_valid), 32'h1);
    checkOutput("t1 pend_sel", 32'(pend_sel), 32'h3);
    checkOutput("t1 pend_data", 32'(pend_data), 32'hBEEF);
    checkOutput("t1 o4 before commit", 32'(obs[3]), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("t1 pend_valid drop", 32'(pend_valid), 32'h0);
    checkOutput("t1 o4", 32'(obs[3]), 32'hBEEF);
    checkOutput("t1 wr_ack high", 32'(wr_ack), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("t1 wr_ack low", 32'(wr_ack), 32'h0);
    checkOutput("t1 others zero", 32'(orAll(3)), 32'h0);
    checkOutput("t1 ack count", 32'(ack_count), 32'd1);

    $display("[TB] back-to-back writes");
    for (int s = 1; s < 16; s++) begin
      applyStimulus(4'(s), 16'(s), 1'b1, w);
      checkOutput("t2 no stall", 32'(w), 32'h0);
    end
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    for (int s = 1; s < 16; s++) begin
      checkOutput($sformatf("t2 o%0d", s + 1), 32'(obs[s]), 32'(s));
    end
    checkOutput("t2 ack count", 32'(ack_count), 32'd16);

    $display("[TB] write to register 0");
    applyStimulus(4'd0, 16'hFFFF, 1'b1, w);
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t3 o1 zero reg", 32'(obs[0]), 32'h0);
    checkOutput("t3 o1 no zero reg", 32'(obs0[0]), 32'hFFFF);
    checkOutput("t3 ack count", 32'(ack_count), 32'd17);

    $display("[TB] hold stalls commit");
    bus.wr_valid = 1'b1;
    bus.wr_sel   = 4'd5;
    bus.wr_data  = 16'h1234;
    e.idx = 4'd5; e.value = 16'h1234; expq.push_back(e);
    @(posedge clk);
    #1;
    hold = 1'b1;
    bus.wr_sel  = 4'd6;
    bus.wr_data = 16'h5678;
    e.idx = 4'd6; e.value = 16'h5678; expq.push_back(e);
    repeat (3) begin
      @(negedge clk);
      checkOutput("t4 wr_ready low", 32'(bus.wr_ready), 32'h0);
      checkOutput("t4 pend_data", 32'(pend_data), 32'h1234);
      checkOutput("t4 pend_sel", 32'(pend_sel), 32'h5);
      checkOutput("t4 no ack", 32'(wr_ack), 32'h0);
      checkOutput("t4 o6 unchanged", 32'(obs[5]), 32'h5);
      @(posedge clk);
    end
    #1;
    hold = 1'b0;
    @(posedge clk);
    #1;
    applyIdle();
    checkOutput("t4 o6", 32'(obs[5]), 32'h1234);
    checkOutput("t4 second pending", 32'(pend_valid), 32'h1);
    checkOutput("t4 second pend_sel", 32'(pend_sel), 32'h6);
    checkOutput("t4 second pend_data", 32'(pend_data), 32'h5678);
    @(posedge clk);
    #1;
    checkOutput("t4 o7", 32'(obs[6]), 32'h5678);
    checkOutput("t4 pend empty", 32'(pend_valid), 32'h0);

    $display("[TB] last write wins");
    applyStimulus(4'd7, 16'hAAAA, 1'b1, w);
    applyStimulus(4'd7, 16'h5555, 1'b1, w);
    applyIdle();
    checkOutput("t5 o8 first", 32'(obs[7]), 32'hAAAA);
    @(posedge clk);
    #1;
    checkOutput("t5 o8 second", 32'(obs[7]), 32'h5555);
    @(posedge clk);
    #1;

    $display("[TB] reset with pending write");
    applyStimulus(4'd9, 16'hC0DE, 1'b0, w);
    applyIdle();
    checkOutput("t6 pend before reset", 32'(pend_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6 pend_valid cleared", 32'(pend_valid), 32'h0);
    checkOutput("t6 o10 zero", 32'(obs[9]), 32'h0);
    checkOutput("t6 all cleared", 32'(orAll(-1)), 32'h0);
    saved_acks = ack_count;
    @(negedge clk);
    checkOutput("t6 no ack in reset", 32'(wr_ack), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6 no ack after reset", 32'(ack_count), 32'(saved_acks));
    applyStimulus(4'd10, 16'h4242, 1'b1, w);
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6 o11 after reset", 32'(obs[10]), 32'h4242);
    checkOutput("t6 o10 still zero", 32'(obs[9]), 32'h0);
    checkOutput("scoreboard drained", 32'(expq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
